// File: rtl/inst_rom_if.sv
// Fetch-side bundle for inst_rom: read address, combinational/registered word, range flag.
// The write port only exists when INSTROM_WRITE_EN is defined.
interface inst_rom_if #(
    parameter int IW = 9,
    parameter int AW = 10
);
    logic [AW-1:0] InstAddress;
    logic [IW-1:0] InstOut;
    logic [IW-1:0] InstOutQ;
    logic          AddrErr;
`ifdef INSTROM_WRITE_EN
    logic          WrEn;
    logic [AW-1:0] WrAddr;
    logic [IW-1:0] WrData;

    modport master (
        output InstAddress, WrEn, WrAddr, WrData,
        input  InstOut, InstOutQ, AddrErr
    );
    modport slave (
        input  InstAddress, WrEn, WrAddr, WrData,
        output InstOut, InstOutQ, AddrErr
    );
`else
    modport master (
        output InstAddress,
        input  InstOut, InstOutQ, AddrErr
    );
    modport slave (
        input  InstAddress,
        output InstOut, InstOutQ, AddrErr
    );
`endif
endinterface

// File: rtl/inst_rom.sv
// Instruction store with combinational read, a registered copy of the read word and a range flag.
// Define INSTROM_WRITE_EN to turn the fixed image into a writable array that reset restores.
module inst_rom #(
    parameter int DEPTH = 1024,
    parameter int IW    = 9,
    parameter int AW    = 10
) (
    input logic       Clk,
    input logic       Reset_n,
    inst_rom_if.slave bus
);

    // Boot image; every address not listed holds zero.
    function automatic logic [IW-1:0] imageWord(input int unsigned addr);
        logic [8:0] word;
        case (addr)
            4:       word = 9'b010001000;
            50:      word = 9'b000001100;
            60:      word = 9'b000011101;
            100:     word = 9'b001011010;
            default: word = 9'b000000000;
        endcase
        return IW'(word);
    endfunction

    logic          readInRange;
    logic [IW-1:0] readWord;

    assign readInRange = 32'(bus.InstAddress) < 32'(DEPTH);

`ifdef INSTROM_WRITE_EN
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IW-1:0] mem [DEPTH];
    logic          writeInRange;

    assign writeInRange = 32'(bus.WrAddr) < 32'(DEPTH);

    // Reset reloads the whole image and wins over a write on the same edge.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= imageWord(i);
            end
        end else if (bus.WrEn && writeInRange) begin
            mem[bus.WrAddr[IDXW-1:0]] <= bus.WrData;
        end
    end

    assign readWord = mem[bus.InstAddress[IDXW-1:0]];
`else
    assign readWord = imageWord(32'(bus.InstAddress));
`endif

    // Out-of-range reads are forced to zero so the array index never matters there.
    assign bus.InstOut = readInRange ? readWord : '0;
    assign bus.AddrErr = !readInRange;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.InstOutQ <= '0;
        end else begin
            bus.InstOutQ <= bus.InstOut;
        end
    end

endmodule

// File: tb/tb_inst_rom.sv
// Scoreboard bench for inst_rom: a 1024-word and a 64-word instance share one random stimulus stream.
// Expected words come from an image table plus a write log; checked on the falling edge.
`timescale 1ns/1ps
module tb_inst_rom;

    localparam int IW          = 9;
    localparam int AW          = 10;
    localparam int BIG_DEPTH   = 1024;
    localparam int SMALL_DEPTH = 64;
`ifdef INSTROM_WRITE_EN
    localparam bit WRITE_EN = 1'b1;
`else
    localparam bit WRITE_EN = 1'b0;
`endif

    typedef struct {
        string         tag;
        logic [IW-1:0] bigOut;
        logic          bigErr;
        logic [IW-1:0] bigQ;
        logic [IW-1:0] smallOut;
        logic          smallErr;
        logic [IW-1:0] smallQ;
    } expect_t;

    logic Clk;
    logic Reset_n;

    int checkCount = 0;
    int passCount  = 0;

    expect_t       scoreboard[$];
    logic [IW-1:0] refBig   [BIG_DEPTH];
    logic [IW-1:0] refSmall [SMALL_DEPTH];
    logic [IW-1:0] qBig;
    logic [IW-1:0] qSmall;
    logic [AW-1:0] curAddr;
    bit            curWrEn;
    logic [AW-1:0] curWrAddr;
    logic [IW-1:0] curWrData;

    int         imgAddr [4] = '{4, 50, 60, 100};
    logic [8:0] imgData [4] = '{9'b010001000, 9'b000001100, 9'b000011101, 9'b001011010};
    int         specialAddr [8] = '{0, 4, 50, 60, 63, 64, 100, 1023};

    inst_rom_if #(.IW(IW), .AW(AW)) bigBus ();
    inst_rom_if #(.IW(IW), .AW(AW)) smallBus ();

    inst_rom #(.DEPTH(BIG_DEPTH), .IW(IW), .AW(AW)) dutBig (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bigBus)
    );

    inst_rom #(.DEPTH(SMALL_DEPTH), .IW(IW), .AW(AW)) dutSmall (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (smallBus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic loadImage();
        foreach (refBig[i])   refBig[i]   = '0;
        foreach (refSmall[i]) refSmall[i] = '0;
        for (int k = 0; k < 4; k++) begin
            if (imgAddr[k] < BIG_DEPTH)   refBig[imgAddr[k]]   = imgData[k];
            if (imgAddr[k] < SMALL_DEPTH) refSmall[imgAddr[k]] = imgData[k];
        end
    endtask

    function automatic logic [IW-1:0] readBig(logic [AW-1:0] a);
        if (int'(a) < BIG_DEPTH) return refBig[a];
        return '0;
    endfunction

    function automatic logic [IW-1:0] readSmall(logic [AW-1:0] a);
        if (int'(a) < SMALL_DEPTH) return refSmall[a[5:0]];
        return '0;
    endfunction

    task automatic checkOutput(string name, logic [IW-1:0] actual, logic [IW-1:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    // One cycle: retire the edge into the model, then drive new inputs and queue their expectation.
    task automatic applyStimulus(string tag, logic [AW-1:0] addr, bit rst,
                                 bit wrEn, logic [AW-1:0] wrAddr, logic [IW-1:0] wrData);
        expect_t e;
        @(posedge Clk);
        if (Reset_n) begin
            qBig   = readBig(curAddr);
            qSmall = readSmall(curAddr);
            if (WRITE_EN && curWrEn) begin
                if (int'(curWrAddr) < BIG_DEPTH)   refBig[curWrAddr]        = curWrData;
                if (int'(curWrAddr) < SMALL_DEPTH) refSmall[curWrAddr[5:0]] = curWrData;
            end
        end
        #1;
        Reset_n = rst;
        if (!rst) begin
            qBig   = '0;
            qSmall = '0;
            if (WRITE_EN) loadImage();
        end
        curAddr   = addr;
        curWrEn   = wrEn;
        curWrAddr = wrAddr;
        curWrData = wrData;
        bigBus.InstAddress   = addr;
        smallBus.InstAddress = addr;
`ifdef INSTROM_WRITE_EN
        bigBus.WrEn     = wrEn;
        bigBus.WrAddr   = wrAddr;
        bigBus.WrData   = wrData;
        smallBus.WrEn   = wrEn;
        smallBus.WrAddr = wrAddr;
        smallBus.WrData = wrData;
`endif
        e.tag      = tag;
        e.bigOut   = readBig(addr);
        e.bigErr   = int'(addr) >= BIG_DEPTH;
        e.bigQ     = qBig;
        e.smallOut = readSmall(addr);
        e.smallErr = int'(addr) >= SMALL_DEPTH;
        e.smallQ   = qSmall;
        scoreboard.push_back(e);
    endtask

    // Monitor: the falling edge sits between address change and the next rising edge.
    always @(negedge Clk) begin
        expect_t e;
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput({e.tag, "/bigOut"},   bigBus.InstOut,           e.bigOut);
            checkOutput({e.tag, "/bigErr"},   IW'(bigBus.AddrErr),      IW'(e.bigErr));
            checkOutput({e.tag, "/bigQ"},     bigBus.InstOutQ,          e.bigQ);
            checkOutput({e.tag, "/smallOut"}, smallBus.InstOut,         e.smallOut);
            checkOutput({e.tag, "/smallErr"}, IW'(smallBus.AddrErr),    IW'(e.smallErr));
            checkOutput({e.tag, "/smallQ"},   smallBus.InstOutQ,        e.smallQ);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            dirAddr [10] = '{50, 4, 60, 0, 1023, 63, 64, 1, 99, 101};
        logic [AW-1:0] a;
        logic [AW-1:0] wa;
        bit            r;
        bit            w;

        Reset_n   = 1'b1;
        curAddr   = '0;
        curWrEn   = 1'b0;
        curWrAddr = '0;
        curWrData = '0;
        qBig      = '0;
        qSmall    = '0;
        loadImage();
        bigBus.InstAddress   = '0;
        smallBus.InstAddress = '0;
`ifdef INSTROM_WRITE_EN
        bigBus.WrEn     = 1'b0;
        bigBus.WrAddr   = '0;
        bigBus.WrData   = '0;
        smallBus.WrEn   = 1'b0;
        smallBus.WrAddr = '0;
        smallBus.WrData = '0;
`endif
        #2 Reset_n = 1'b0;

        applyStimulus("resetHold",       10'd100, 1'b0, 1'b0, '0, '0);
        applyStimulus("resetAcrossEdge", 10'd100, 1'b0, 1'b0, '0, '0);
        applyStimulus("resetRelease",    10'd100, 1'b1, 1'b0, '0, '0);
        applyStimulus("firstEdge",       10'd100, 1'b1, 1'b0, '0, '0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus("directed", AW'(dirAddr[i]), 1'b1, 1'b0, '0, '0);
        end

        applyStimulus("writeOld",     10'd4,  1'b1, 1'b1, 10'd4,  9'b111111111);
        applyStimulus("writeNew",     10'd4,  1'b1, 1'b0, '0,     '0);
        applyStimulus("writeReset",   10'd4,  1'b0, 1'b0, '0,     '0);
        applyStimulus("writeRelease", 10'd4,  1'b1, 1'b0, '0,     '0);
        applyStimulus("writeHigh",    10'd70, 1'b1, 1'b1, 10'd70, 9'b101010101);
        applyStimulus("readHigh",     10'd70, 1'b1, 1'b1, 10'd63, 9'b110011001);
        applyStimulus("readTop",      10'd63, 1'b1, 1'b0, '0,     '0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) a = AW'(specialAddr[$urandom_range(0, 7)]);
            else                           a = AW'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 0) wa = AW'($urandom_range(0, 127));
            else                           wa = AW'($urandom_range(0, 1023));
            r = $urandom_range(0, 39) != 0;
            w = $urandom_range(0, 2) == 0;
            applyStimulus("random", a, r, w, wa, IW'($urandom));
        end

        @(negedge Clk);
        #1;
        for (int i = 0; i < 4 && scoreboard.size() > 0; i++) @(negedge Clk);
        #1;
        if (scoreboard.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: got %0d pending, expected 0", scoreboard.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
